// File: rtl/paddle_reader_pkg.sv
// Shared definitions for the paddle position reader: FSM encoding and
// default measurement limits.
package paddle_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int MAX_LINES_DEF = 255;
  localparam int POS_MAX_DEF   = 239;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/paddle_reader_sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a
// single-cycle rising-edge pulse generator.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/paddle_reader.sv
// Measures the hsync line count from vsync to the paddle comparator edge,
// clamps it and publishes a two-tap averaged paddle position once per frame.
module paddle_reader
  import paddle_reader_pkg::*;
#(
  parameter int MAX_LINES = MAX_LINES_DEF,
  parameter int POS_MAX   = POS_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hpaddle,
  input  logic       hsync,
  input  logic       vsync,
  output logic [7:0] paddle_pos,
  output logic       paddle_valid,
  output logic       paddle_timeout
);

  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LINES);
  localparam logic [7:0]       POS_M = 8'(POS_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= MAX_L) ? MAX_L : c + 1'b1;
  endfunction

  function automatic logic [7:0] clamp_pos(input logic [CNT_W-1:0] s);
    return (s > POS_M) ? POS_M : s;
  endfunction

  function automatic logic [7:0] filt_avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8:1];
  endfunction

  logic hpaddle_s, hsync_rise, vsync_rise;
  logic unused_hpaddle_rise, unused_hsync_lvl, unused_vsync_lvl;

  sync_rise_detect u_hpaddle_sync (
    .clk   (clk),
    .reset (reset),
    .din   (hpaddle),
    .level (hpaddle_s),
    .rise  (unused_hpaddle_rise)
  );

  sync_rise_detect u_hsync_sync (
    .clk   (clk),
    .reset (reset),
    .din   (hsync),
    .level (unused_hsync_lvl),
    .rise  (hsync_rise)
  );

  sync_rise_detect u_vsync_sync (
    .clk   (clk),
    .reset (reset),
    .din   (vsync),
    .level (unused_vsync_lvl),
    .rise  (vsync_rise)
  );

  state_t           state, state_d;
  logic [CNT_W-1:0] line_cnt, line_cnt_d;
  logic             cap_vld, cap_timeout;
  logic [CNT_W-1:0] cap_sample;

  // A vsync edge always restarts the count, so a frame whose measurement
  // was aborted still gets measured itself.
  always_comb begin
    state_d     = state;
    line_cnt_d  = line_cnt;
    cap_vld     = 1'b0;
    cap_timeout = 1'b0;
    cap_sample  = line_cnt;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (vsync_rise) begin
          state_d    = ST_MEASURE;
          line_cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (hpaddle_s) begin
          cap_vld = 1'b1;
          state_d = ST_DONE;
        end else if (vsync_rise) begin
          cap_vld     = 1'b1;
          cap_timeout = 1'b1;
        end else if (line_cnt == MAX_L) begin
          cap_vld     = 1'b1;
          cap_timeout = 1'b1;
          cap_sample  = MAX_L;
          state_d     = ST_DONE;
        end else if (hsync_rise) begin
          line_cnt_d = sat_inc(line_cnt);
        end
        if (vsync_rise) begin
          state_d    = ST_MEASURE;
          line_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: capture decision
  logic [CNT_W-1:0] sample_p0;
  logic             timeout_p0;
  logic             vld_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      line_cnt   <= '0;
      sample_p0  <= '0;
      timeout_p0 <= 1'b0;
      vld_p0     <= 1'b0;
    end else begin
      state    <= state_d;
      line_cnt <= line_cnt_d;
      vld_p0   <= cap_vld;
      if (cap_vld) begin
        sample_p0  <= cap_sample;
        timeout_p0 <= cap_timeout;
      end
    end
  end

  // Stage p1: clamp, filter and publish
  logic first_pub;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_pub      <= 1'b1;
      paddle_pos     <= '0;
      paddle_valid   <= 1'b0;
      paddle_timeout <= 1'b0;
    end else begin
      paddle_valid <= vld_p0;
      if (vld_p0) begin
        paddle_pos     <= first_pub ? clamp_pos(sample_p0)
                                    : filt_avg(paddle_pos, clamp_pos(sample_p0));
        paddle_timeout <= timeout_p0;
        first_pub      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paddle_reader.sv
// Directed bench for paddle_reader: frame-by-frame stimulus with
// hand-computed positions, timeout flags and pulse counts.
module tb_paddle_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       hpaddle;
  logic       hsync;
  logic       vsync;
  logic [7:0] paddle_pos;
  logic       paddle_valid;
  logic       paddle_timeout;

  paddle_reader #(.MAX_LINES(255), .POS_MAX(239)) dut (
    .clk            (clk),
    .reset          (reset),
    .hpaddle        (hpaddle),
    .hsync          (hsync),
    .vsync          (vsync),
    .paddle_pos     (paddle_pos),
    .paddle_valid   (paddle_valid),
    .paddle_timeout (paddle_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int vld_cnt  = 0;
  int run      = 0;
  int max_run  = 0;
  int pos_q[$];
  int to_q[$];

  always @(negedge clk) begin
    if (paddle_valid === 1'b1) begin
      vld_cnt++;
      pos_q.push_back(int'(paddle_pos));
      to_q.push_back(int'(paddle_timeout));
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    cycles(3);
    vsync = 1'b0;
    cycles(3);
  endtask

  task automatic lines(input int n);
    repeat (n) begin
      hsync = 1'b1;
      cycles(2);
      hsync = 1'b0;
      cycles(2);
    end
  endtask

  function automatic int nth_last(input int q[$], input int k);
    if (q.size() < k) return -1;
    return q[q.size() - k];
  endfunction

  task automatic expect_pub(input string tag, input int base, input int npub,
                            input int pos, input int to);
    check({tag, "_count"}, vld_cnt - base, npub);
    check({tag, "_pos"}, nth_last(pos_q, 1), pos);
    check({tag, "_timeout"}, nth_last(to_q, 1), to);
  endtask

  initial begin
    int base;
    int lat;
    reset   = 1'b0;
    hpaddle = 1'b0;
    hsync   = 1'b0;
    vsync   = 1'b0;
    cycles(3);
    check("rst_pos", paddle_pos, 0);
    check("rst_valid", paddle_valid, 0);
    check("rst_timeout", paddle_timeout, 0);
    reset = 1'b1;
    cycles(3);

    // Frame 1: 100 lines, first publish loads directly; also measure latency
    base = vld_cnt;
    vsync_pulse();
    lines(100);
    hpaddle = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (paddle_valid) break;
    end
    check("latency", lat, 4);
    cycles(4);
    expect_pub("f1", base, 1, 100, 0);
    hpaddle = 1'b0;
    cycles(4);

    // Frame 2: 50 lines -> (100+50)>>1
    base = vld_cnt;
    vsync_pulse();
    lines(50);
    hpaddle = 1'b1;
    cycles(8);
    expect_pub("f2", base, 1, 75, 0);

    // Frame 3: hpaddle still high at vsync -> sample 0 -> 75>>1
    base = vld_cnt;
    vsync_pulse();
    lines(10);
    cycles(4);
    expect_pub("f3_held", base, 1, 37, 0);
    hpaddle = 1'b0;
    cycles(4);

    // Frame 4: no paddle edge, saturates at 255, clamped to 239 -> (37+239)>>1
    base = vld_cnt;
    vsync_pulse();
    lines(260);
    cycles(4);
    expect_pub("f4_timeout", base, 1, 138, 1);

    // Frame 5: vsync at line 30 aborts, next frame captures at line 20
    base = vld_cnt;
    vsync_pulse();
    lines(30);
    vsync_pulse();
    lines(20);
    hpaddle = 1'b1;
    cycles(8);
    check("f5_count", vld_cnt - base, 2);
    check("f5_abort_pos", nth_last(pos_q, 2), 84);
    check("f5_abort_timeout", nth_last(to_q, 2), 1);
    check("f5_pos", nth_last(pos_q, 1), 52);
    check("f5_timeout", nth_last(to_q, 1), 0);
    hpaddle = 1'b0;
    cycles(4);

    // Reset in the middle of a measurement
    vsync_pulse();
    lines(60);
    reset = 1'b0;
    #1;
    check("midrst_pos", paddle_pos, 0);
    check("midrst_valid", paddle_valid, 0);
    check("midrst_timeout", paddle_timeout, 0);
    cycles(2);
    reset = 1'b1;
    base = vld_cnt;
    hpaddle = 1'b1;
    lines(20);
    cycles(8);
    check("postrst_quiet", vld_cnt - base, 0);
    hpaddle = 1'b0;
    cycles(4);

    // First publish after reset loads unfiltered
    base = vld_cnt;
    vsync_pulse();
    lines(40);
    hpaddle = 1'b1;
    cycles(8);
    expect_pub("postrst_f1", base, 1, 40, 0);
    hpaddle = 1'b0;
    cycles(4);

    check("valid_width", max_run, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
